// File: rtl/grf_wport_arbiter_pkg.sv
// grf_wport_arbiter_pkg
//   Shared widths, the buffered late-result record, the arbiter FSM
//   encoding and the D-stage hazard helper used by grf_wport_arbiter
//   and late_result_fifo.
package grf_wport_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic [REG_W-1:0]  a3;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] pc;
  } late_entry_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  // A nonzero source/destination is hazardous if a late write to it is
  // outstanding or is being issued this very cycle.
  function automatic logic reg_hazard(
    input logic [REG_W-1:0] r,
    input logic [NREG-1:0]  busy,
    input logic             iss_valid,
    input logic [REG_W-1:0] iss_a3
  );
    return (r != '0) && (busy[r] || (iss_valid && (iss_a3 == r)));
  endfunction

endpackage

// File: rtl/late_result_fifo.sv
// late_result_fifo
//   Circular buffer of late-unit results waiting for the GRF write port.
//   DEPTH must be a power of two (pointers wrap naturally).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, data_i     enqueue request and record (ignored when full)
//   pop_i              dequeue request (ignored when empty)
//   data_o             current head record
//   count_o            number of occupied entries
//   full_o, empty_o    occupancy flags
module late_result_fifo
  import grf_wport_arbiter_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  late_entry_t      data_i,
  input  logic             pop_i,
  output late_entry_t      data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  late_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers/count define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter
//   Owns the single GRF write port. The in-order W stage has priority;
//   late (out-of-order) results are buffered and drained whenever W does
//   not use the port. A starvation timer forces a one-cycle Hold of the W
//   stage so a blocked head always drains. A scoreboard of outstanding
//   late writes drives the D-stage stall.
// Ports:
//   Clk, Rst_n                         clock, asynchronous active-low reset
//   W_RFWr/W_A3/W_WD/W_PC              W-stage write request
//   Late_Req/Late_A3/Late_WD/Late_PC   late result offer
//   Late_Ready                         buffer accepts an offer this cycle
//   Iss_Valid/Iss_A3                   late op issue (marks dest busy)
//   D_A1/D_A2/D_A3                     D-stage register fields
//   Stall                              D-stage stall (combinational)
//   Hold                               freeze W stage (registered)
//   RFWr/A3/WD/WPC                     GRF write port
//   Busy                               outstanding late-write vector
module grf_wport_arbiter
  import grf_wport_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              W_RFWr,
  input  logic [REG_W-1:0]  W_A3,
  input  logic [DATA_W-1:0] W_WD,
  input  logic [DATA_W-1:0] W_PC,
  input  logic              Late_Req,
  input  logic [REG_W-1:0]  Late_A3,
  input  logic [DATA_W-1:0] Late_WD,
  input  logic [DATA_W-1:0] Late_PC,
  output logic              Late_Ready,
  input  logic              Iss_Valid,
  input  logic [REG_W-1:0]  Iss_A3,
  input  logic [REG_W-1:0]  D_A1,
  input  logic [REG_W-1:0]  D_A2,
  input  logic [REG_W-1:0]  D_A3,
  output logic              Stall,
  output logic              Hold,
  output logic              RFWr,
  output logic [REG_W-1:0]  A3,
  output logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] WPC,
  output logic [NREG-1:0]   Busy
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = $clog2(STARVE_MAX) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(STARVE_MAX - 1);

  arb_state_e        state_q, state_d;
  logic              hold_q, hold_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [NREG-1:0]   busy_q, busy_d;

  late_entry_t       late_in, head;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic              has_head, w_grant, drain_we, port_we;

  // ---------------------------------------------------------------- buffer
  assign late_in    = '{a3: Late_A3, wd: Late_WD, pc: Late_PC};
  assign Late_Ready = !fifo_full;
  assign fifo_push  = Late_Req && Late_Ready;

  late_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .push_i  (fifo_push),
    .data_i  (late_in),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ----------------------------------------------------------------- grant
  assign has_head = !fifo_empty;
  assign w_grant  = W_RFWr && (W_A3 != '0) && !hold_q;
  assign fifo_pop = has_head && !w_grant;
  // A buffered $0 result consumes its drain slot but never writes.
  assign drain_we = fifo_pop && (head.a3 != '0);

  always_comb begin
    port_we = 1'b0;
    A3      = '0;
    WD      = '0;
    WPC     = '0;
    if (w_grant) begin
      port_we = 1'b1;
      A3      = W_A3;
      WD      = W_WD;
      WPC     = W_PC;
    end else if (fifo_pop) begin
      port_we = drain_we;
      A3      = head.a3;
      WD      = head.wd;
      WPC     = head.pc;
    end
  end

  // Reset is asynchronous; the write enable is masked while it is asserted
  // so a pending W request cannot reach the GRF during reset.
  assign RFWr = Rst_n && port_we;

  // ------------------------------------------------------------ starvation
  always_comb begin
    wait_d = wait_q;
    if (!has_head || fifo_pop) begin
      wait_d = '0;
    end else if (wait_q != WAIT_LIMIT) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        if (has_head && w_grant && (wait_q == WAIT_LIMIT)) state_d = FORCE;
      end
      FORCE:   state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
    hold_d = (state_d == FORCE);
  end

  assign Hold = hold_q;

  // ------------------------------------------------------------ scoreboard
  // Clear precedes set so an issue to a register draining this cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (drain_we) busy_d[head.a3] = 1'b0;
    if (Iss_Valid && (Iss_A3 != '0)) busy_d[Iss_A3] = 1'b1;
    busy_d[0] = 1'b0;
  end

  assign Busy  = busy_q;
  assign Stall = Rst_n && (reg_hazard(D_A1, busy_q, Iss_Valid, Iss_A3) ||
                           reg_hazard(D_A2, busy_q, Iss_Valid, Iss_A3) ||
                           reg_hazard(D_A3, busy_q, Iss_Valid, Iss_A3));

  // ------------------------------------------------------------- registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= NORMAL;
      hold_q  <= 1'b0;
      wait_q  <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
    end
  end

  a_fifo_flags : assert property (@(posedge Clk) disable iff (!Rst_n)
    fifo_empty == (fifo_count == '0));

endmodule

// File: tb/tb_grf_wport_arbiter.sv
`timescale 1ns/1ps
module tb_grf_wport_arbiter;
  import grf_wport_arbiter_pkg::*;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              W_RFWr;
  logic [4:0]        W_A3;
  logic [31:0]       W_WD, W_PC;
  logic              Late_Req;
  logic [4:0]        Late_A3;
  logic [31:0]       Late_WD, Late_PC;
  logic              Late_Ready;
  logic              Iss_Valid;
  logic [4:0]        Iss_A3, D_A1, D_A2, D_A3;
  logic              Stall, Hold, RFWr;
  logic [4:0]        A3;
  logic [31:0]       WD, WPC, Busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  late_entry_t mq[$];
  int          m_wait;
  bit          m_hold;
  bit [31:0]   m_busy;

  always #5 Clk = ~Clk;

  grf_wport_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .W_RFWr     (W_RFWr),
    .W_A3       (W_A3),
    .W_WD       (W_WD),
    .W_PC       (W_PC),
    .Late_Req   (Late_Req),
    .Late_A3    (Late_A3),
    .Late_WD    (Late_WD),
    .Late_PC    (Late_PC),
    .Late_Ready (Late_Ready),
    .Iss_Valid  (Iss_Valid),
    .Iss_A3     (Iss_A3),
    .D_A1       (D_A1),
    .D_A2       (D_A2),
    .D_A3       (D_A3),
    .Stall      (Stall),
    .Hold       (Hold),
    .RFWr       (RFWr),
    .A3         (A3),
    .WD         (WD),
    .WPC        (WPC),
    .Busy       (Busy)
  );

  task automatic drive_idle();
    W_RFWr = 1'b0; W_A3 = '0; W_WD = '0; W_PC = '0;
    Late_Req = 1'b0; Late_A3 = '0; Late_WD = '0; Late_PC = '0;
    Iss_Valid = 1'b0; Iss_A3 = '0;
    D_A1 = '0; D_A2 = '0; D_A3 = '0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    drive_idle();
    W_RFWr = 1'b1; W_A3 = 5'd3; Iss_Valid = 1'b1; Iss_A3 = 5'd7; D_A1 = 5'd7;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL reset_rfwr: got %0b expected 0", RFWr); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", Stall); end
    checks++; if (Hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %0b expected 0", Hold); end
    checks++; if (Busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", Busy); end
    checks++; if (Late_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", Late_Ready); end
    drive_idle();
    #2 Rst_n = 1'b1;
    step();
    settle();
    checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL reset_after_rfwr: got %0b expected 0", RFWr); end
    checks++; if (Busy !== 32'h0) begin errors++; $display("FAIL reset_after_busy: got %0h expected 0", Busy); end
    step();
  endtask

  task automatic test_simple_late();
    drive_idle(); Iss_Valid = 1'b1; Iss_A3 = 5'd8; D_A1 = 5'd8;
    settle();
    checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL simple_iss_stall: got %0b expected 1", Stall); end
    step();
    for (int i = 0; i < 2; i++) begin
      drive_idle(); D_A1 = 5'd8;
      settle();
      checks++; if (Busy[8] !== 1'b1) begin errors++; $display("FAIL simple_busy8: got %0b expected 1", Busy[8]); end
      checks++; if (Stall !== 1'b1) begin errors++; $display("FAIL simple_stall: got %0b expected 1", Stall); end
      step();
    end
    drive_idle(); Late_Req = 1'b1; Late_A3 = 5'd8; Late_WD = 32'hDEADBEEF; Late_PC = 32'h0000_0400;
    settle();
    checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL simple_push_rfwr: got %0b expected 0", RFWr); end
    step();
    drive_idle(); D_A1 = 5'd8;
    settle();
    checks++; if (RFWr !== 1'b1) begin errors++; $display("FAIL simple_drain_rfwr: got %0b expected 1", RFWr); end
    checks++; if (A3 !== 5'd8) begin errors++; $display("FAIL simple_drain_a3: got %0d expected 8", A3); end
    checks++; if (WD !== 32'hDEADBEEF) begin errors++; $display("FAIL simple_drain_wd: got %0h expected deadbeef", WD); end
    checks++; if (WPC !== 32'h400) begin errors++; $display("FAIL simple_drain_pc: got %0h expected 400", WPC); end
    step();
    drive_idle(); D_A1 = 5'd8;
    settle();
    checks++; if (Busy[8] !== 1'b0) begin errors++; $display("FAIL simple_busy_clear: got %0b expected 0", Busy[8]); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL simple_stall_clear: got %0b expected 0", Stall); end
    step();
  endtask

  task automatic test_full_buffer();
    int exp_a3  [10] = '{3, 3, 3, 3, 3, 10, 3, 11, 12, 0};
    bit exp_rdy [10] = '{1, 1, 0, 0, 0, 0, 1, 0, 1, 1};
    for (int c = 0; c < 10; c++) begin
      drive_idle();
      if (c <= 6) begin
        W_RFWr = 1'b1; W_A3 = 5'd3; W_WD = 32'h3333; W_PC = 32'h1000 + 32'(c * 4);
        Late_Req = 1'b1;
        Late_A3 = (c == 0) ? 5'd10 : (c == 1) ? 5'd11 : 5'd12;
        Late_WD = 32'hA000 + 32'(Late_A3);
      end
      settle();
      checks++; if (Late_Ready !== exp_rdy[c]) begin errors++; $display("FAIL full_ready c%0d: got %0b expected %0b", c, Late_Ready, exp_rdy[c]); end
      checks++; if (Hold !== (c == 5)) begin errors++; $display("FAIL full_hold c%0d: got %0b expected %0b", c, Hold, c == 5); end
      checks++; if (RFWr !== (c < 9)) begin errors++; $display("FAIL full_rfwr c%0d: got %0b expected %0b", c, RFWr, c < 9); end
      if (c < 9) begin
        checks++; if (A3 !== 5'(exp_a3[c])) begin errors++; $display("FAIL full_a3 c%0d: got %0d expected %0d", c, A3, exp_a3[c]); end
      end
      if (c >= 7 && c <= 8) begin
        checks++; if (WD !== 32'hA000 + 32'(exp_a3[c])) begin errors++; $display("FAIL full_wd c%0d: got %0h expected %0h", c, WD, 32'hA000 + 32'(exp_a3[c])); end
      end
      step();
    end
  endtask

  task automatic test_starvation();
    int forces = 0;
    for (int c = 0; c < 9; c++) begin
      drive_idle();
      W_RFWr = 1'b1; W_A3 = 5'd3; W_WD = 32'h3333_3333; W_PC = 32'h2000;
      if (c == 0) begin
        Late_Req = 1'b1; Late_A3 = 5'd13; Late_WD = 32'h1313_1313; Late_PC = 32'h3000;
      end
      settle();
      if (Hold === 1'b1 && A3 === 5'd13) forces++;
      checks++; if (Hold !== (c == 5)) begin errors++; $display("FAIL starve_hold c%0d: got %0b expected %0b", c, Hold, c == 5); end
      checks++; if (RFWr !== 1'b1) begin errors++; $display("FAIL starve_rfwr c%0d: got %0b expected 1", c, RFWr); end
      checks++; if (A3 !== ((c == 5) ? 5'd13 : 5'd3)) begin errors++; $display("FAIL starve_a3 c%0d: got %0d expected %0d", c, A3, (c == 5) ? 13 : 3); end
      checks++; if (WD !== ((c == 5) ? 32'h1313_1313 : 32'h3333_3333)) begin errors++; $display("FAIL starve_wd c%0d: got %0h", c, WD); end
      step();
    end
    checks++; if (forces != 1) begin errors++; $display("FAIL starve_force_count: got %0d expected 1", forces); end
  endtask

  task automatic test_same_cycle();
    drive_idle(); Iss_Valid = 1'b1; Iss_A3 = 5'd9;
    step();
    drive_idle(); Late_Req = 1'b1; Late_A3 = 5'd9; Late_WD = 32'h99;
    settle();
    checks++; if (Busy[9] !== 1'b1) begin errors++; $display("FAIL same_busy_set: got %0b expected 1", Busy[9]); end
    step();
    drive_idle(); Iss_Valid = 1'b1; Iss_A3 = 5'd9;
    settle();
    checks++; if (RFWr !== 1'b1 || A3 !== 5'd9) begin errors++; $display("FAIL same_drain: got rfwr %0b a3 %0d expected 1 9", RFWr, A3); end
    step();
    drive_idle(); Late_Req = 1'b1; Late_A3 = 5'd9; Late_WD = 32'h98;
    settle();
    checks++; if (Busy[9] !== 1'b1) begin errors++; $display("FAIL same_set_wins: got %0b expected 1", Busy[9]); end
    step();
    drive_idle();
    settle();
    checks++; if (RFWr !== 1'b1 || WD !== 32'h98) begin errors++; $display("FAIL same_drain2: got rfwr %0b wd %0h expected 1 98", RFWr, WD); end
    step();
    drive_idle();
    settle();
    checks++; if (Busy[9] !== 1'b0) begin errors++; $display("FAIL same_busy_clear: got %0b expected 0", Busy[9]); end
    step();
  endtask

  task automatic test_zero_reg();
    drive_idle(); Late_Req = 1'b1; Late_A3 = 5'd14; Late_WD = 32'h14;
    step();
    drive_idle(); W_RFWr = 1'b1; W_A3 = 5'd0; W_WD = 32'hFFFF; Iss_Valid = 1'b1; Iss_A3 = 5'd0;
    settle();
    checks++; if (RFWr !== 1'b1 || A3 !== 5'd14 || WD !== 32'h14) begin errors++; $display("FAIL zero_pop: got rfwr %0b a3 %0d wd %0h expected 1 14 14", RFWr, A3, WD); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0b expected 0", Stall); end
    step();
    drive_idle(); Late_Req = 1'b1; Late_A3 = 5'd0; Late_WD = 32'hBAD;
    settle();
    checks++; if (Busy !== 32'h0) begin errors++; $display("FAIL zero_busy: got %0h expected 0", Busy); end
    step();
    drive_idle();
    settle();
    checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL zero_a3_write: got %0b expected 0", RFWr); end
    step();
    drive_idle(); Late_Req = 1'b1; Late_A3 = 5'd15; Late_WD = 32'h15;
    step();
    drive_idle();
    settle();
    checks++; if (RFWr !== 1'b1 || A3 !== 5'd15) begin errors++; $display("FAIL zero_next_head: got rfwr %0b a3 %0d expected 1 15", RFWr, A3); end
    step();
  endtask

  task automatic test_reset_midop();
    for (int c = 0; c < 6; c++) begin
      drive_idle();
      W_RFWr = 1'b1; W_A3 = 5'd3; W_WD = 32'h3;
      if (c == 0) begin Iss_Valid = 1'b1; Iss_A3 = 5'd5; Late_Req = 1'b1; Late_A3 = 5'd20; end
      if (c == 1) begin Late_Req = 1'b1; Late_A3 = 5'd21; end
      if (c == 5) D_A1 = 5'd5;
      settle();
      if (c < 5) step();
    end
    checks++; if (Hold !== 1'b1 || Busy[5] !== 1'b1 || Late_Ready !== 1'b0) begin errors++; $display("FAIL midop_setup: got hold %0b busy5 %0b ready %0b expected 1 1 0", Hold, Busy[5], Late_Ready); end
    #1 Rst_n = 1'b0;
    #1;
    checks++; if (Hold !== 1'b0) begin errors++; $display("FAIL midop_hold: got %0b expected 0", Hold); end
    checks++; if (Busy !== 32'h0) begin errors++; $display("FAIL midop_busy: got %0h expected 0", Busy); end
    checks++; if (RFWr !== 1'b0) begin errors++; $display("FAIL midop_rfwr: got %0b expected 0", RFWr); end
    checks++; if (Late_Ready !== 1'b1 || Stall !== 1'b0) begin errors++; $display("FAIL midop_ready_stall: got %0b %0b expected 1 0", Late_Ready, Stall); end
    #1 drive_idle();
    #1 Rst_n = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      drive_idle();
      settle();
      checks++; if (RFWr !== 1'b0 || Late_Ready !== 1'b1 || Busy !== 32'h0) begin errors++; $display("FAIL midop_after c%0d: got rfwr %0b ready %0b busy %0h", c, RFWr, Late_Ready, Busy); end
      step();
    end
  endtask

  task automatic test_random();
    bit          pend = 1'b0;
    bit          exp_ready, exp_rf, exp_stall, wg, popped, pushed;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd, exp_pc;
    logic [4:0]  fld [3];
    late_entry_t hd, ne;
    bit [31:0]   nb;

    #2 Rst_n = 1'b0;
    drive_idle();
    #2 Rst_n = 1'b1;
    mq.delete(); m_wait = 0; m_hold = 1'b0; m_busy = '0;
    step();

    for (int cyc = 0; cyc < 400; cyc++) begin
      W_RFWr = ($urandom_range(0, 3) != 0);
      W_A3 = 5'($urandom_range(0, 7));
      W_WD = $urandom; W_PC = $urandom;
      if (!pend) begin
        Late_Req = ($urandom_range(0, 2) == 0);
        Late_A3 = 5'($urandom_range(0, 7));
        Late_WD = $urandom; Late_PC = $urandom;
      end
      Iss_Valid = ($urandom_range(0, 3) == 0);
      Iss_A3 = 5'($urandom_range(0, 7));
      D_A1 = 5'($urandom_range(0, 7));
      D_A2 = 5'($urandom_range(0, 7));
      D_A3 = 5'($urandom_range(0, 7));
      settle();

      exp_ready = (mq.size() < DEPTH);
      wg = W_RFWr && (W_A3 != 0) && !m_hold;
      popped = !wg && (mq.size() > 0);
      hd = popped ? mq[0] : '0;
      exp_rf = 1'b0; exp_a3 = '0; exp_wd = '0; exp_pc = '0;
      if (wg) begin
        exp_rf = 1'b1; exp_a3 = W_A3; exp_wd = W_WD; exp_pc = W_PC;
      end else if (popped) begin
        exp_rf = (hd.a3 != 0); exp_a3 = hd.a3; exp_wd = hd.wd; exp_pc = hd.pc;
      end
      fld[0] = D_A1; fld[1] = D_A2; fld[2] = D_A3;
      exp_stall = 1'b0;
      for (int k = 0; k < 3; k++)
        if (fld[k] != 0 && (m_busy[fld[k]] || (Iss_Valid && Iss_A3 == fld[k]))) exp_stall = 1'b1;

      checks++; if (Late_Ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc%0d: got %0b expected %0b", cyc, Late_Ready, exp_ready); end
      checks++; if (Hold !== m_hold) begin errors++; $display("FAIL rnd_hold cyc%0d: got %0b expected %0b", cyc, Hold, m_hold); end
      checks++; if (Busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc%0d: got %0h expected %0h", cyc, Busy, m_busy); end
      checks++; if (Stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc%0d: got %0b expected %0b", cyc, Stall, exp_stall); end
      checks++; if (RFWr !== exp_rf) begin errors++; $display("FAIL rnd_rfwr cyc%0d: got %0b expected %0b", cyc, RFWr, exp_rf); end
      if (exp_rf) begin
        checks++;
        if (A3 !== exp_a3 || WD !== exp_wd || WPC !== exp_pc) begin
          errors++;
          $display("FAIL rnd_port cyc%0d: got %0d/%0h/%0h expected %0d/%0h/%0h", cyc, A3, WD, WPC, exp_a3, exp_wd, exp_pc);
        end
      end

      pushed = Late_Req && exp_ready;
      nb = m_busy;
      if (popped && hd.a3 != 0) nb[hd.a3] = 1'b0;
      if (Iss_Valid && Iss_A3 != 0) nb[Iss_A3] = 1'b1;
      m_busy = nb;
      if (m_hold) m_hold = 1'b0;
      else if (wg && mq.size() > 0 && m_wait == int'(STARVE_MAX) - 1) m_hold = 1'b1;
      if (mq.size() == 0 || popped) m_wait = 0;
      else if (m_wait < int'(STARVE_MAX) - 1) m_wait++;
      if (popped) void'(mq.pop_front());
      if (pushed) begin
        ne.a3 = Late_A3; ne.wd = Late_WD; ne.pc = Late_PC;
        mq.push_back(ne);
      end
      pend = Late_Req && !exp_ready;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_simple_late();
    test_full_buffer();
    test_starvation();
    test_same_cycle();
    test_zero_reg();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/grf_wport_arbiter.md
Name: grf_wport_arbiter

Overview:
- Owns the single write port of the D-stage general register file (32x32, $0 hard-wired to zero, same-cycle write-to-read bypass inside the GRF).
- Shares the port between two writers: the in-order W-stage writeback and a late multi-cycle unit (mult/div style) that returns results out of pipeline order.
- Holds a register scoreboard so the D stage stalls on registers with an outstanding late write.
- Uses a starvation timer to force a drain slot when the W stage keeps the port busy.

Parameters:
- DEPTH, 2: late-result buffer entries (power of 2, at least 2).
- STARVE_MAX, 4: cycles a buffered result may wait before Hold is forced (at least 1).

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset: asynchronous assert, active-low.
- W_RFWr  in  1  W-stage write request.
- W_A3  in  5  W-stage destination register.
- W_WD  in  32  W-stage write data.
- W_PC  in  32  W-stage PC.
- Late_Req  in  1  late unit offers a result.
- Late_A3  in  5  late result destination.
- Late_WD  in  32  late result data.
- Late_PC  in  32  late result PC.
- Late_Ready  out  1  buffer can accept this cycle.
- Iss_Valid  in  1  a late-unit op issues this cycle.
- Iss_A3  in  5  its destination.
- D_A1  in  5  D-stage source register 1.
- D_A2  in  5  D-stage source register 2.
- D_A3  in  5  D-stage destination register.
- Stall  out  1  D-stage stall request (combinational).
- Hold  out  1  freeze W stage (registered).
- RFWr  out  1  write enable to GRF.
- A3  out  5  write address to GRF.
- WD  out  32  write data to GRF.
- WPC  out  32  write PC to GRF.
- Busy  out  32  scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset, Rst_n=0 at any time including mid-drain:
  - buffer count=0, wait counter=0, Hold=0, Busy=0, FSM=NORMAL.
  - RFWr=0, Late_Ready=1, Stall=0.
  - All buffered results are discarded.
- Buffer:
  - Circular FIFO of {A3, WD, PC} with DEPTH entries.
  - Push when Late_Req && Late_Ready.
  - Late_Ready = (count < DEPTH), with no pop look-ahead.
  - Push and pop in the same cycle are both legal; count is unchanged and pointers wrap modulo DEPTH.
  - Late_Req while Late_Ready=0 is ignored; the requester keeps Late_Req high until it is accepted.
  - Late_A3=0 is pushed and drained normally, but never written (RFWr=0 in its drain cycle).
- Grant, combinational from current state, zero latency:
  - W_grant = W_RFWr && W_A3!=0 && !Hold.
  - If W_grant: port carries the W fields.
  - Else if count>0: pop the head onto the port.
  - Else: RFWr=0.
  - A buffered result therefore reaches the GRF at least 1 cycle after push.
- FSM:
  - NORMAL -> FORCE when count>0 and wait counter reaches STARVE_MAX-1 while the head is being blocked by W_grant. Hold is registered to 1 on that edge.
  - FORCE: Hold=1, W request ignored, head popped. Next state is NORMAL and Hold is cleared.
  - The W stage must present the same request again the cycle after Hold.
- Wait counter:
  - Increments each cycle the head is present but not popped.
  - Clears on every pop and whenever count=0.
  - Saturates at STARVE_MAX-1.
- Scoreboard:
  - Busy[Iss_A3] sets on the edge after Iss_Valid (no set when Iss_A3=0).
  - Clears on the edge its entry is written.
  - Set and clear of the same register in the same cycle: set wins.
- Stall, for each field in {D_A1, D_A2, D_A3} that is nonzero:
  - Stall=1 if Busy of that register is 1.
  - Stall=1 if Iss_Valid and Iss_A3 equals that register.
  - The D_A3 check prevents write-after-write (WAW) hazards against a pending late write.
- Drain writes of a register cleared from Busy become visible to D reads through the GRF bypass in the same cycle.

Decomposition:
- Shared package holds:
  - REG_W=5, DATA_W=32, NREG=32.
  - Typedef late_entry_t {A3, WD, PC}.
  - FSM encoding {NORMAL, FORCE}.
- One natural sub-module, late_result_fifo: a parameterized DEPTH FIFO with push, pop, count, full and empty.
- Arbitration, FSM and scoreboard stay in the top module.

Test Plan:
- Reset mid-operation:
  - Stimulus: count=2, Busy[5]=1, Hold=1, then Rst_n=0 for a single cycle (asynchronous, not clock-aligned).
  - Required: all outputs take reset values immediately, and nothing is written afterward.
- Simple late write:
  - Stimulus: Iss_Valid A3=8; 3 cycles later Late_Req A3=8 WD=0xDEADBEEF; W idle.
  - Required: Busy[8]=1 and Stall=1 when D_A1=8. The following cycle RFWr=1 A3=8 WD=0xDEADBEEF, with Busy[8] cleared on that edge.
- Full buffer:
  - Stimulus: W_RFWr=1 every cycle, 2 late pushes, third Late_Req held.
  - Required: Late_Ready=0 after the second push. Hold rises after 4 blocked cycles. The head drains and Late_Ready returns to 1. The third push is accepted the cycle Late_Ready=1.
- Starvation:
  - Stimulus: STARVE_MAX=4, one buffered entry, W writes $3 continuously.
  - Required: exactly one FORCE cycle in which RFWr carries the late entry; the $3 write lands the cycle after Hold falls.
- Same-cycle set and clear:
  - Stimulus: entry A3=9 drains in the same cycle Iss_Valid A3=9.
  - Required: Busy[9]=1 after the edge.
- $0 handling:
  - Stimulus: W_A3=0 with W_RFWr=1; Iss_A3=0; D_A1=0.
  - Required: the buffer head is popped in that cycle, Busy=0, Stall=0.
